video_grid_capture: RTL and testbench
=====================================

VIDEO_GRID_CAPTURE -- requirements
Module: video_grid_capture

Interface
REQ-001 Parameter P_PARAM_N, default 32, meaning grid columns.
REQ-002 Parameter P_PARAM_M, default 24, meaning grid rows.
REQ-003 Parameter P_H_ACTIVE, default 1024, meaning active pixels per line.
REQ-004 Parameter P_V_ACTIVE, default 768, meaning active lines per frame.
REQ-005 Parameter P_HSYNC_POL / P_VSYNC_POL, default 1 / 1, meaning sync asserted level.
REQ-006 Parameter P_LUMA_TH, default 384, meaning alive threshold on 10-bit R+G+B sum.
REQ-007 clk  input  1  pixel clock; all logic on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 video_red / video_green / video_blue  input  8 each  pixel colour.
REQ-010 video_hsync, video_vsync, video_de  input  1 each  sync and data-enable.
REQ-011 grid_out  output  P_PARAM_N*P_PARAM_M  last committed cell grid; bit row*P_PARAM_N+col.
REQ-012 grid_valid  output  1  one-cycle pulse when grid_out updates.
REQ-013 frame_error  output  1  one-cycle pulse when a malformed frame is discarded.
REQ-014 frame_count  output  16  committed-frame count, wraps 0xFFFF->0.

Function
REQ-015 All video inputs SHALL be registered once before use; all timing below is relative to registered signals.
REQ-016 Cell size SHALL be CELL_W=P_H_ACTIVE/P_PARAM_N, CELL_H=P_V_ACTIVE/P_PARAM_M (32x32 at defaults); both exact integers.
REQ-017 States: WAIT_SYNC, ACTIVE, COMMIT.
REQ-018 WAIT_SYNC: ignore DE; on vsync active edge -> ACTIVE, clear x, y, error latch.
REQ-019 ACTIVE: x counts DE-high pixels of current line, cleared on DE rising edge; y increments on each DE falling edge.
REQ-020 Sample point: x%CELL_W==CELL_W/2 and y%CELL_H==CELL_H/2; write shadow[(y/CELL_H)*P_PARAM_N + x/CELL_W] = (R+G+B >= P_LUMA_TH), sum 10 bits, no overflow.
REQ-021 Error latch SET on: line with DE-high count != P_H_ACTIVE; y reaching P_V_ACTIVE+1; DE high while vsync asserted.
REQ-022 Out-of-range pixels (x>=P_H_ACTIVE or y>=P_V_ACTIVE) SHALL NOT write shadow.
REQ-023 ACTIVE, next vsync active edge -> COMMIT for one cycle.
REQ-024 COMMIT: if y==P_V_ACTIVE and error latch clear: grid_out<=shadow, grid_valid=1, frame_count+1; else frame_error=1, grid_out unchanged. Then -> ACTIVE with x, y, error latch cleared.
REQ-025 Latency: grid_valid/frame_error SHALL assert exactly 2 clk after raw vsync active edge at the input pins.
REQ-026 grid_valid and frame_error SHALL never assert in the same cycle.
REQ-027 Shadow SHALL persist across discarded frames; grid_out changes only in COMMIT.
REQ-028 Vsync held asserted for many cycles counts as one edge.

Reset
REQ-029 rst_n low SHALL immediately force: state WAIT_SYNC, grid_out 0, grid_valid 0, frame_error 0, frame_count 0, shadow 0, counters 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; no pulse until one full well-formed frame after the second post-reset vsync edge.

Verification
REQ-031 Reset, then two 1024x768 frames with odd cell columns white (255,255,255), even black -> after 2nd vsync: grid_out=0xAAAAAAAA per row, grid_valid 1 cycle, frame_count=1.
REQ-032 Frame with pixel (R,G,B)=(128,128,127) sum 383 at all sample points -> grid_out all 0; sum 384 -> all 1.
REQ-033 Line 100 carries 1023 DE pixels -> frame_error pulse, grid_out and frame_count unchanged.
REQ-034 Frame with 767 active lines -> frame_error; next good frame -> grid_valid.
REQ-035 rst_n low at line 400 of a frame -> outputs 0 immediately; first grid_valid only after next full frame.
REQ-036 frame_count preset via 65536 good frames (or forced) -> wraps to 0, grid_valid still pulses.

Source files
------------

// File: rtl/video_grid_capture.sv
// rtl/video_grid_capture.sv - samples one pixel per cell of each video frame into an on/off grid
module video_grid_capture #(
  parameter int P_PARAM_N   = 32,
  parameter int P_PARAM_M   = 24,
  parameter int P_H_ACTIVE  = 1024,
  parameter int P_V_ACTIVE  = 768,
  parameter bit P_HSYNC_POL = 1'b1,
  parameter bit P_VSYNC_POL = 1'b1,
  parameter int P_LUMA_TH   = 384
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     video_red,
  input  logic [7:0]                     video_green,
  input  logic [7:0]                     video_blue,
  input  logic                           video_hsync,
  input  logic                           video_vsync,
  input  logic                           video_de,
  output logic [P_PARAM_N*P_PARAM_M-1:0] grid_out,
  output logic                           grid_valid,
  output logic                           frame_error,
  output logic [15:0]                    frame_count
);

  localparam int CELL_W = P_H_ACTIVE / P_PARAM_N;
  localparam int CELL_H = P_V_ACTIVE / P_PARAM_M;
  localparam int CELLS  = P_PARAM_N * P_PARAM_M;
  localparam int XW     = $clog2(P_H_ACTIVE + 2);
  localparam int YW     = $clog2(P_V_ACTIVE + 2);
  localparam int IW     = (CELLS > 1) ? $clog2(CELLS) : 1;

  // Counters saturate one past the legal maximum so an over-long line or
  // frame stays detectable without wrapping back into range.
  localparam logic [XW-1:0] X_FULL  = XW'(P_H_ACTIVE);
  localparam logic [XW-1:0] X_SAT   = XW'(P_H_ACTIVE + 1);
  localparam logic [YW-1:0] Y_FULL  = YW'(P_V_ACTIVE);
  localparam logic [YW-1:0] Y_SAT   = YW'(P_V_ACTIVE + 1);
  localparam logic [9:0]    LUMA_TH = 10'(P_LUMA_TH);

  typedef enum logic [1:0] {
    ST_WAIT_SYNC,
    ST_ACTIVE,
    ST_COMMIT
  } state_t;

  // Registered copies of the pins; sync levels are stored as "asserted" flags
  logic [7:0] red_q, green_q, blue_q;
  logic       hs_act_q, vs_act_q, de_q;
  logic       vs_prev_q, de_prev_q;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            err_q, err_d;
  logic [CELLS-1:0] shadow_q, shadow_d;
  logic [CELLS-1:0] grid_q, grid_d;
  logic            grid_valid_q, grid_valid_d;
  logic            frame_error_q, frame_error_d;
  logic [15:0]     frame_count_q, frame_count_d;

  logic            vs_rise, de_rise, de_fall;
  logic [XW-1:0]   px;
  logic [9:0]      luma;
  logic            alive;
  logic            sample_hit;
  logic [IW-1:0]   cell_idx;

  // Horizontal sync carries no information this block needs
  logic unused_hsync;
  assign unused_hsync = hs_act_q;

  // Input capture stage plus one-cycle history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      hs_act_q  <= 1'b0;
      vs_act_q  <= 1'b0;
      de_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
    end else begin
      red_q     <= video_red;
      green_q   <= video_green;
      blue_q    <= video_blue;
      hs_act_q  <= (video_hsync == P_HSYNC_POL);
      vs_act_q  <= (video_vsync == P_VSYNC_POL);
      de_q      <= video_de;
      vs_prev_q <= vs_act_q;
      de_prev_q <= de_q;
    end
  end

  // Edge detection, pixel position within the line and sample-point decode
  always_comb begin
    vs_rise    = vs_act_q & ~vs_prev_q;
    de_rise    = de_q & ~de_prev_q;
    de_fall    = ~de_q & de_prev_q;
    px         = de_rise ? '0 : x_q;
    luma       = {2'b00, red_q} + {2'b00, green_q} + {2'b00, blue_q};
    alive      = (luma >= LUMA_TH);
    sample_hit = de_q && (px < X_FULL) && (y_q < Y_FULL)
                 && ((int'(px) % CELL_W) == (CELL_W / 2))
                 && ((int'(y_q) % CELL_H) == (CELL_H / 2));
    cell_idx   = IW'((int'(y_q) / CELL_H) * P_PARAM_N + int'(px) / CELL_W);
  end

  // Frame FSM: counts lines/pixels, fills the shadow grid, commits on vsync
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    err_d         = err_q;
    shadow_d      = shadow_q;
    grid_d        = grid_q;
    grid_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      ST_WAIT_SYNC: begin
        if (vs_rise) begin
          state_d = ST_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          err_d   = 1'b0;
        end
      end

      ST_ACTIVE: begin
        if (de_q) begin
          x_d = (px != X_SAT) ? px + XW'(1) : px;
          if (vs_act_q) begin
            err_d = 1'b1;
          end
          if (sample_hit) begin
            shadow_d[cell_idx] = alive;
          end
        end
        if (de_fall) begin
          if (x_q != X_FULL) begin
            err_d = 1'b1;
          end
          if (y_q >= Y_FULL) begin
            err_d = 1'b1;
          end
          if (y_q != Y_SAT) begin
            y_d = y_q + YW'(1);
          end
        end
        if (vs_rise) begin
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        if ((y_q == Y_FULL) && !err_q) begin
          grid_d        = shadow_q;
          grid_valid_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          frame_error_d = 1'b1;
        end
        state_d = ST_ACTIVE;
        x_d     = '0;
        y_d     = '0;
        err_d   = 1'b0;
      end

      default: begin
        state_d = ST_WAIT_SYNC;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT_SYNC;
      x_q           <= '0;
      y_q           <= '0;
      err_q         <= 1'b0;
      shadow_q      <= '0;
      grid_q        <= '0;
      grid_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      err_q         <= err_d;
      shadow_q      <= shadow_d;
      grid_q        <= grid_d;
      grid_valid_q  <= grid_valid_d;
      frame_error_q <= frame_error_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign grid_out    = grid_q;
  assign grid_valid  = grid_valid_q;
  assign frame_error = frame_error_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_video_grid_capture.sv
// tb/tb_video_grid_capture.sv - directed and randomized frames against a per-pixel grid model
module tb_video_grid_capture;

  localparam int N      = 4;
  localparam int M      = 3;
  localparam int H      = 32;
  localparam int V      = 24;
  localparam int CW     = H / N;
  localparam int CH     = V / M;
  localparam int CELLS  = N * M;
  localparam int IW     = $clog2(CELLS);
  localparam int TH     = 384;
  localparam int HBLANK = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       video_red = '0, video_green = '0, video_blue = '0;
  logic             video_hsync = 1'b0, video_vsync = 1'b0, video_de = 1'b0;
  logic [CELLS-1:0] grid_out;
  logic             grid_valid, frame_error;
  logic [15:0]      frame_count;

  video_grid_capture #(
    .P_PARAM_N(N), .P_PARAM_M(M), .P_H_ACTIVE(H), .P_V_ACTIVE(V),
    .P_HSYNC_POL(1'b1), .P_VSYNC_POL(1'b1), .P_LUMA_TH(TH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .video_red(video_red), .video_green(video_green), .video_blue(video_blue),
    .video_hsync(video_hsync), .video_vsync(video_vsync), .video_de(video_de),
    .grid_out(grid_out), .grid_valid(grid_valid), .frame_error(frame_error),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit               armed;
  bit               frame_ok;
  int               lines_seen;
  logic [CELLS-1:0] m_shadow, m_grid;
  logic [15:0]      m_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    armed      = 1'b0;
    frame_ok   = 1'b1;
    lines_seen = 0;
    m_shadow   = '0;
    m_grid     = '0;
    m_count    = '0;
  endtask

  // mode: 0 random, 1 odd cell columns white, 2 sum 383, 3 sum 384
  task automatic send_line(input int ly, input int len, input int mode);
    for (int i = 0; i < len; i++) begin
      logic [7:0] r, g, b;
      case (mode)
        0: begin
          r = 8'($urandom_range(255, 0));
          g = 8'($urandom_range(255, 0));
          b = 8'($urandom_range(255, 0));
        end
        1: begin
          r = (((i / CW) % 2) == 1) ? 8'hFF : 8'h00;
          g = r;
          b = r;
        end
        2: begin r = 8'd128; g = 8'd128; b = 8'd127; end
        default: begin r = 8'd128; g = 8'd128; b = 8'd128; end
      endcase
      video_red = r; video_green = g; video_blue = b; video_de = 1'b1;
      if (armed && ly < V && i < H && (i % CW) == CW / 2 && (ly % CH) == CH / 2)
        m_shadow[IW'((ly / CH) * N + i / CW)] = ((int'(r) + int'(g) + int'(b)) >= TH);
      tick();
    end
    video_de = 1'b0; video_red = '0; video_green = '0; video_blue = '0;
    if (armed) begin
      lines_seen++;
      if (len != H) frame_ok = 1'b0;
    end
    for (int k = 0; k < HBLANK; k++) begin
      video_hsync = (k == 1 || k == 2);
      tick();
    end
    video_hsync = 1'b0;
  endtask

  task automatic send_frame(input int nlines, input int mode, input int bad_line, input int bad_len);
    for (int ly = 0; ly < nlines; ly++)
      send_line(ly, (ly == bad_line) ? bad_len : H, mode);
    repeat (4) tick();
  endtask

  // Raises vsync and checks the commit/discard pulse two clocks after capture
  task automatic do_vsync(input bit de_glitch);
    bit ev, ee;
    ev = 1'b0;
    ee = 1'b0;
    if (!armed) begin
      armed = 1'b1;
    end else if (frame_ok && lines_seen == V) begin
      m_grid = m_shadow;
      m_count++;
      ev = 1'b1;
    end else begin
      ee = 1'b1;
    end
    frame_ok   = 1'b1;
    lines_seen = 0;

    video_vsync = 1'b1;
    tick();
    check("pulse_early1", {grid_valid, frame_error}, 2'b00);
    tick();
    check("pulse_early2", {grid_valid, frame_error}, 2'b00);
    tick();
    check("grid_valid", grid_valid, ev);
    check("frame_error", frame_error, ee);
    check("grid_out", grid_out, m_grid);
    check("frame_count", frame_count, m_count);
    tick();
    check("pulse_width", {grid_valid, frame_error}, 2'b00);
    if (de_glitch) begin
      video_de = 1'b1;
      tick();
      video_de = 1'b0;
      frame_ok = 1'b0;
    end
    repeat (3) tick();
    video_vsync = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) tick();
    check("rst_grid", grid_out, '0);
    check("rst_valid", grid_valid, 1'b0);
    check("rst_error", frame_error, 1'b0);
    check("rst_count", frame_count, 16'd0);
    rst_n = 1'b1;
    tick();

    // First edge only arms; two stripe frames commit
    do_vsync(1'b0);
    send_frame(V, 1, -1, 0);
    do_vsync(1'b0);
    check("stripes_grid", grid_out, 12'hAAA);
    check("stripes_count", frame_count, 16'd1);
    send_frame(V, 1, -1, 0);
    do_vsync(1'b0);

    // Threshold boundary
    send_frame(V, 2, -1, 0);
    do_vsync(1'b0);
    check("sum383_grid", grid_out, 12'h000);
    send_frame(V, 3, -1, 0);
    do_vsync(1'b0);
    check("sum384_grid", grid_out, 12'hFFF);

    // Random content
    repeat (3) begin
      send_frame(V, 0, -1, 0);
      do_vsync(1'b0);
    end

    // Malformed frames followed by recovery
    send_frame(V, 0, 10, H - 1);
    do_vsync(1'b0);
    send_frame(V - 1, 0, -1, 0);
    do_vsync(1'b0);
    send_frame(V, 0, -1, 0);
    do_vsync(1'b0);
    send_frame(V + 1, 0, -1, 0);
    do_vsync(1'b0);
    send_frame(V, 0, 5, H + 1);
    do_vsync(1'b0);
    send_frame(V, 0, -1, 0);
    do_vsync(1'b1);
    send_frame(V, 0, -1, 0);
    do_vsync(1'b0);
    send_frame(V, 0, -1, 0);
    do_vsync(1'b0);

    // Frame counter wrap
    force dut.frame_count_q = 16'hFFFF;
    tick();
    tick();
    release dut.frame_count_q;
    m_count = 16'hFFFF;
    send_frame(V, 0, -1, 0);
    do_vsync(1'b0);
    check("wrap_count", frame_count, 16'd0);

    // Reset in the middle of a frame
    send_frame(12, 0, -1, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_grid", grid_out, '0);
    check("midrst_count", frame_count, 16'd0);
    check("midrst_pulses", {grid_valid, frame_error}, 2'b00);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(12, 0, -1, 0);
    do_vsync(1'b0);
    send_frame(V, 0, -1, 0);
    do_vsync(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
